// File: rtl/fifoc_mch.sv
// Multi-channel FIFO controller for one shared dual-port RAM split into NCH regions.
// Optional sticky overflow/underflow flags are built when FIFOC_MCH_ERRFLAG_EN is defined.
module fifoc_mch #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CHBIT   = 2,
    parameter int unsigned ADDRBIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [CHBIT-1:0]           wrch,
    input  logic                       fifowr,
    input  logic [CHBIT-1:0]           rdch,
    input  logic                       fiford,
    input  logic [NCH-1:0]             fifofsh,
    input  logic [ADDRBIT:0]           afthr,
    output logic [NCH-1:0]             fifofull,
    output logic [NCH-1:0]             notempty,
    output logic [NCH-1:0]             almfull,
    output logic [NCH*(ADDRBIT+1)-1:0] fifolen,
    output logic                       write,
    output logic [CHBIT+ADDRBIT-1:0]   wraddr,
    output logic                       read,
    output logic [CHBIT+ADDRBIT-1:0]   rdaddr,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       errclr
);

    localparam int unsigned LW = ADDRBIT + 1;

    logic [ADDRBIT-1:0] wrcnt_q [NCH];
    logic [ADDRBIT-1:0] wrcnt_d [NCH];
    logic [LW-1:0]      len_q   [NCH];
    logic [LW-1:0]      len_d   [NCH];

    always_comb begin
        fifofull = '0;
        notempty = '0;
        almfull  = '0;
        fifolen  = '0;
        for (int k = 0; k < NCH; k++) begin
            fifofull[k]          = len_q[k][ADDRBIT];
            notempty[k]          = |len_q[k];
            almfull[k]           = (len_q[k] >= afthr);
            fifolen[k*LW +: LW]  = len_q[k];
        end
    end

    assign write  = fifowr & ~fifofull[wrch] & ~fifofsh[wrch];
    assign read   = fiford & notempty[rdch] & ~fifofsh[rdch];
    assign wraddr = {wrch, wrcnt_q[wrch]};
    // No stored read pointer: the oldest entry sits len entries behind the write count.
    assign rdaddr = {rdch, wrcnt_q[rdch] - len_q[rdch][ADDRBIT-1:0]};

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            logic wr_k;
            logic rd_k;
            wr_k       = write & (wrch == CHBIT'(k));
            rd_k       = read & (rdch == CHBIT'(k));
            wrcnt_d[k] = wrcnt_q[k];
            len_d[k]   = len_q[k];
            if (fifofsh[k]) begin
                wrcnt_d[k] = '0;
                len_d[k]   = '0;
            end else begin
                if (wr_k) begin
                    wrcnt_d[k] = wrcnt_q[k] + ADDRBIT'(1);
                end
                if (wr_k && !rd_k) begin
                    len_d[k] = len_q[k] + LW'(1);
                end else if (rd_k && !wr_k) begin
                    len_d[k] = len_q[k] - LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int k = 0; k < NCH; k++) begin
                wrcnt_q[k] <= '0;
                len_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                wrcnt_q[k] <= wrcnt_d[k];
                len_q[k]   <= len_d[k];
            end
        end
    end

`ifdef FIFOC_MCH_ERRFLAG_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // Clear wins over a same-cycle set.
    always_comb begin
        ovf_d = ovf_q | (fifowr & fifofull[wrch] & ~fifofsh[wrch]);
        udf_d = udf_q | (fiford & ~notempty[rdch] & ~fifofsh[rdch]);
        if (errclr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_errclr;
    assign unused_errclr = errclr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifoc_mch.sv
// Randomized bench for fifoc_mch against a per-channel queue model of stored addresses.
module tb_fifoc_mch;

    localparam int NCH = 4;
    localparam int CHBIT = 2;
    localparam int ADDRBIT = 4;
    localparam int DEPTH = 16;
    localparam int LW = ADDRBIT + 1;

    logic                     clk;
    logic                     rst_;
    logic [CHBIT-1:0]         wrch;
    logic                     fifowr;
    logic [CHBIT-1:0]         rdch;
    logic                     fiford;
    logic [NCH-1:0]           fifofsh;
    logic [ADDRBIT:0]         afthr;
    logic [NCH-1:0]           fifofull;
    logic [NCH-1:0]           notempty;
    logic [NCH-1:0]           almfull;
    logic [NCH*LW-1:0]        fifolen;
    logic                     write;
    logic [CHBIT+ADDRBIT-1:0] wraddr;
    logic                     read;
    logic [CHBIT+ADDRBIT-1:0] rdaddr;
    logic                     ovf;
    logic                     udf;
    logic                     errclr;

    fifoc_mch #(.NCH(NCH), .CHBIT(CHBIT), .ADDRBIT(ADDRBIT)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .wrch     (wrch),
        .fifowr   (fifowr),
        .rdch     (rdch),
        .fiford   (fiford),
        .fifofsh  (fifofsh),
        .afthr    (afthr),
        .fifofull (fifofull),
        .notempty (notempty),
        .almfull  (almfull),
        .fifolen  (fifolen),
        .write    (write),
        .wraddr   (wraddr),
        .read     (read),
        .rdaddr   (rdaddr),
        .ovf      (ovf),
        .udf      (udf),
        .errclr   (errclr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each channel holds the full RAM addresses of its stored entries, oldest first.
    int mq [NCH][$];
    int wptr [NCH];
    bit ovf_m;
    bit udf_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            mq[k].delete();
            wptr[k] = 0;
        end
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    task automatic check_state();
        logic [NCH-1:0]    ef;
        logic [NCH-1:0]    ene;
        logic [NCH-1:0]    eaf;
        logic [NCH*LW-1:0] elen;
        for (int k = 0; k < NCH; k++) begin
            ef[k]               = (mq[k].size() == DEPTH);
            ene[k]              = (mq[k].size() != 0);
            eaf[k]              = (mq[k].size() >= int'(afthr));
            elen[k*LW +: LW]    = LW'(mq[k].size());
        end
        check("fifolen", 32'(fifolen), 32'(elen));
        check("fifofull", 32'(fifofull), 32'(ef));
        check("notempty", 32'(notempty), 32'(ene));
        check("almfull", 32'(almfull), 32'(eaf));
`ifdef FIFOC_MCH_ERRFLAG_EN
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("udf", 32'(udf), 32'(udf_m));
`else
        check("ovf", 32'(ovf), 32'd0);
        check("udf", 32'(udf), 32'd0);
`endif
    endtask

    // One clock cycle: check registered state, drive a request, check the memory side.
    task automatic cycle(input int wc, input bit w, input int rc, input bit r,
                         input logic [NCH-1:0] fsh, input bit clr);
        bit ew;
        bit er;
        @(negedge clk);
        check_state();
        wrch    = CHBIT'(wc);
        fifowr  = w;
        rdch    = CHBIT'(rc);
        fiford  = r;
        fifofsh = fsh;
        errclr  = clr;
        #1;
        ew = w && (mq[wc].size() < DEPTH) && !fsh[wc];
        er = r && (mq[rc].size() > 0) && !fsh[rc];
        check("write", 32'(write), 32'(ew));
        check("read", 32'(read), 32'(er));
        if (ew) check("wraddr", 32'(wraddr), 32'(wc * DEPTH + wptr[wc]));
        if (er) check("rdaddr", 32'(rdaddr), 32'(mq[rc][0]));
        if (clr) begin
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (w && mq[wc].size() == DEPTH && !fsh[wc]) ovf_m = 1'b1;
            if (r && mq[rc].size() == 0 && !fsh[rc]) udf_m = 1'b1;
        end
        if (er) void'(mq[rc].pop_front());
        if (ew) begin
            mq[wc].push_back(wc * DEPTH + wptr[wc]);
            wptr[wc] = (wptr[wc] + 1) % DEPTH;
        end
        for (int k = 0; k < NCH; k++) begin
            if (fsh[k]) begin
                mq[k].delete();
                wptr[k] = 0;
            end
        end
    endtask

    initial begin
        rst_    = 1'b0;
        wrch    = '0;
        fifowr  = 1'b0;
        rdch    = '0;
        fiford  = 1'b0;
        fifofsh = '0;
        errclr  = 1'b0;
        afthr   = '0;
        model_clear();
        #12;
        check_state();
        afthr = 5'd5;
        #1;
        check_state();
        @(negedge clk);
        rst_ = 1'b1;

        // Fill channel 2 to the brim, then write+read it together while full.
        for (int i = 0; i < DEPTH; i++) cycle(2, 1, 0, 0, '0, 0);
        cycle(2, 1, 2, 1, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, '0, 1);

        // Write ch0 while reading ch1 in the same cycle.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, '0, 0);
        cycle(0, 1, 1, 1, '0, 0);

        // Almost-full threshold boundaries on ch1.
        cycle(0, 0, 0, 0, 4'hf, 0);
        afthr = 5'd12;
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);
        afthr = 5'd0;
        cycle(0, 0, 0, 0, '0, 0);
        afthr = 5'd17;
        cycle(0, 0, 0, 0, '0, 0);

        // Flush ch1 at len 5 while writing it; ch0 keeps its contents.
        cycle(0, 0, 0, 0, 4'hf, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0, 0);
        cycle(1, 1, 0, 0, 4'b0010, 0);
        cycle(1, 0, 1, 1, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);

        // Wrap on ch3: 20 writes and 18 reads interleaved.
        for (int i = 0; i < 20; i++) cycle(3, 1, 3, (i >= 2), '0, 0);
        cycle(0, 0, 0, 0, '0, 0);
        check("ch3_final_len", 32'(fifolen[3*LW +: LW]), 32'd2);

        // Random phases with varying read/write mix and thresholds.
        for (int p = 0; p < 16; p++) begin
            int pw;
            int pr;
            pw = $urandom_range(95, 5);
            pr = $urandom_range(95, 5);
            case ($urandom_range(3, 0))
                0:       afthr = 5'd0;
                1:       afthr = 5'($urandom_range(31, 17));
                default: afthr = 5'($urandom_range(16, 1));
            endcase
            for (int i = 0; i < 150; i++) begin
                logic [NCH-1:0] fsh;
                fsh = '0;
                if ($urandom_range(99, 0) < 2) fsh[$urandom_range(3, 0)] = 1'b1;
                cycle($urandom_range(3, 0), ($urandom_range(99, 0) < pw),
                      $urandom_range(3, 0), ($urandom_range(99, 0) < pr),
                      fsh, ($urandom_range(99, 0) < 4));
            end
        end

        // Asynchronous reset mid-operation discards everything.
        for (int i = 0; i < 4; i++) cycle(i, 1, 0, 0, '0, 0);
        @(negedge clk);
        fifowr = 1'b0;
        fiford = 1'b0;
        fifofsh = '0;
        errclr = 1'b0;
        afthr = 5'd3;
        #2;
        rst_ = 1'b0;
        #1;
        model_clear();
        check_state();
        @(negedge clk);
        rst_ = 1'b1;
        cycle(1, 1, 1, 1, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifoc_mch.md
# fifoc_mch

Multi-channel FIFO control for a shared, externally instantiated memory, partitioned into NCH equal regions of 2^ADDRBIT entries. Per channel it tracks write count and fill length and produces full, not-empty and almost-full flags. Each channel supports an independent flush. It sits between multi-queue datapaths (per-lane buffers, per-flow queues) and a single dual-port RAM, and replaces one FIFO controller per queue.

## Interface
- NCH, 4, number of channels (queues)
- CHBIT, 2, channel select width; NCH must equal 2^CHBIT
- ADDRBIT, 4, per-channel address width; depth per channel is 2^ADDRBIT
- clk  in  1  clock, all state on rising edge
- rst_  in  1  reset, asynchronous, active-low; clock clk
- wrch  in  CHBIT  channel targeted by fifowr
- fifowr  in  1  write request
- rdch  in  CHBIT  channel targeted by fiford
- fiford  in  1  read request
- fifofsh  in  NCH  per-channel flush, one bit per channel
- afthr  in  ADDRBIT+1  almost-full threshold, shared by all channels
- fifofull  out  NCH  channel length equals 2^ADDRBIT
- notempty  out  NCH  channel length non-zero
- almfull  out  NCH  channel length >= afthr
- fifolen  out  NCH*(ADDRBIT+1)  packed lengths; channel k occupies bits [k*(ADDRBIT+1) +: ADDRBIT+1]
- write  out  1  memory write enable
- wraddr  out  CHBIT+ADDRBIT  {wrch, write count of wrch}
- read  out  1  memory read enable
- rdaddr  out  CHBIT+ADDRBIT  {rdch, write count of rdch minus length of rdch, modulo 2^ADDRBIT}
- ovf  out  1  see Configuration
- udf  out  1  see Configuration
- errclr  in  1  clears ovf/udf; see Configuration

## Operation
- Per channel k, state: wrcnt[k] (ADDRBIT bits), len[k] (ADDRBIT+1 bits). There is no stored read pointer. The read offset is wrcnt[k] - len[k][ADDRBIT-1:0], which wraps naturally.
- write = fifowr & !fifofull[wrch] & !fifofsh[wrch].
- read = fiford & notempty[rdch] & !fifofsh[rdch].
- Requests to a full channel (write) or an empty channel (read) are dropped. There is no retry.
- On write: wrcnt[wrch] increments and wraps from 2^ADDRBIT-1 to 0.
- Length update per channel: +1 on write only, -1 on read only, unchanged if both are on the same channel. Different channels update independently in the same cycle.
- Read and write on the same channel in the same cycle while that channel is full: the write is blocked (fifofull) and the read proceeds, so len decrements.
- Read and write on the same channel while it is empty: the read is blocked and the write proceeds, so len becomes 1. There is no write-through to the read port.
- Flush of channel k: wrcnt[k] and len[k] become 0 on the next edge. Flush has priority over any read or write to k in that cycle, and those are suppressed. Other channels are unaffected.
- Flags are combinational from registered len:
  - fifofull[k] = len[k][ADDRBIT]
  - notempty[k] = |len[k]
  - almfull[k] = (len[k] >= afthr), unsigned compare
- afthr = 0 forces almfull high; afthr > 2^ADDRBIT forces it low.

## Timing
- write, read, wraddr and rdaddr are combinational from the request inputs and registered state, valid in the same cycle as the request. The memory samples them on the same edge.
- Flags and fifolen reflect an operation one cycle after the edge on which it is accepted.
- Read data latency is owned by the external memory. This block adds none.
- Reset, asynchronous: all wrcnt/len = 0, so fifofull = 0, notempty = 0, fifolen = 0, ovf = udf = 0. almfull = 1 only if afthr = 0. Reset mid-operation discards all contents.
- Back-to-back writes to one channel are accepted every cycle until full. Each channel holds exactly 2^ADDRBIT entries.

## Configuration
- Macro FIFOC_MCH_ERRFLAG_EN.
- Defined:
  - ovf sets when fifowr arrives while fifofull[wrch] and not fifofsh[wrch].
  - udf sets when fiford arrives while !notempty[rdch] and not fifofsh[rdch].
  - Both are sticky until errclr. errclr has priority over a set in the same cycle.
- Undefined: ovf and udf are tied to 0, errclr is ignored, and no flops are generated.

## Test plan
- Reset, then write 16 entries to channel 2 (ADDRBIT=4) -> wraddr offsets 0..15; fifofull[2]=1 and fifolen ch2=16 one cycle after the 16th write; other channels stay at 0.
- Channel 2 full, then a 17th write plus a read on channel 2 in the same cycle -> write=0, read=1, rdaddr={2,0}, len=15. With FIFOC_MCH_ERRFLAG_EN: ovf=1 until errclr.
- Write ch0 and read ch1 in the same cycle (ch1 len=3) -> ch0 len +1, ch1 len=2, both enables high, addresses on distinct channel regions.
- Wrap: 20 writes and 18 reads interleaved on ch3 -> wraddr offset wraps 15->0; rdaddr offset always equals wrcnt-len mod 16; final len=2.
- afthr=12: fill ch1 to 11 -> almfull[1]=0; 12th write -> almfull[1]=1 next cycle; afthr=0 -> all almfull=1.
- fifofsh[1] in the same cycle as a write to ch1 at len=5 -> write=0; len and wrcnt of ch1 become 0, notempty[1]=0; ch0 contents and length untouched.
